// File: rtl/fir.sv
`default_nettype none
// ============================================================================
// Module      : fir
// Description : 11-tap serial-MAC FIR filter, AXI-Lite config, AXI-Stream data
// Revision    : 1.0 - initial release
// ============================================================================
module fir #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-Lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // AXI-Stream in
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    // AXI-Stream out
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int c_IDX_W = $clog2(Tape_Num);
    localparam int c_TAP_BASE = 32;

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_WAIT_IN = 2'd1;
    localparam logic [1:0] c_S_CALC    = 2'd2;
    localparam logic [1:0] c_S_OUT     = 2'd3;

    localparam logic [pADDR_WIDTH-1:0] c_ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_LEN  = pADDR_WIDTH'(16);

    logic [1:0]             r_state;
    logic                   r_awready, r_wready, r_arready, r_rvalid;
    logic [pDATA_WIDTH-1:0] r_rdata;
    logic                   r_ss_tready, r_sm_tvalid, r_sm_tlast;
    logic [pDATA_WIDTH-1:0] r_sm_tdata;
    logic                   r_ap_start, r_ap_done, r_ap_idle;
    logic [pDATA_WIDTH-1:0] r_data_length, r_out_cnt, r_acc;
    logic [pDATA_WIDTH-1:0] r_tap  [Tape_Num];
    logic [pDATA_WIDTH-1:0] r_hist [Tape_Num];
    logic [c_IDX_W-1:0]     r_idx;

    logic                   w_wr_fire, w_rd_fire, w_start, w_in_fire, w_out_fire;
    logic                   w_last_out;
    logic [pDATA_WIDTH-1:0] w_len_eff, w_prod, w_rd_val;
    logic                   w_unused;

    assign w_unused   = ss_tlast;  // frame end is counted from data_length instead

    assign w_wr_fire  = r_awready & awvalid & wvalid;
    assign w_rd_fire  = r_arready & arvalid;
    assign w_start    = w_wr_fire && (awaddr == c_ADDR_CTRL) && wdata[0] && r_ap_idle;
    assign w_in_fire  = r_ss_tready & ss_tvalid;
    assign w_out_fire = r_sm_tvalid & sm_tready;
    assign w_len_eff  = (r_data_length == '0) ? pDATA_WIDTH'(1) : r_data_length;
    assign w_last_out = (r_out_cnt == w_len_eff);
    // Same-width product keeps exactly the low word of the signed 64-bit result.
    assign w_prod     = r_tap[r_idx] * r_hist[r_idx];

    always_comb begin
        w_rd_val = '0;
        if (araddr == c_ADDR_CTRL) begin
            w_rd_val = pDATA_WIDTH'({r_ap_idle, r_ap_done, r_ap_start});
        end else if (araddr == c_ADDR_LEN) begin
            w_rd_val = r_data_length;
        end
        for (int i = 0; i < Tape_Num; i++) begin
            if (araddr == pADDR_WIDTH'(c_TAP_BASE + 4 * i)) begin
                w_rd_val = r_tap[i];
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= !r_awready && awvalid && wvalid;
            r_wready  <= !r_awready && awvalid && wvalid;
            r_arready <= !r_arready && !r_rvalid && arvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_data_length <= '0;
            for (int i = 0; i < Tape_Num; i++) r_tap[i] <= '0;
        end else if (w_wr_fire && r_ap_idle) begin
            if (awaddr == c_ADDR_LEN) r_data_length <= wdata;
            for (int i = 0; i < Tape_Num; i++) begin
                if (awaddr == pADDR_WIDTH'(c_TAP_BASE + 4 * i)) r_tap[i] <= wdata;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state     <= c_S_IDLE;
            r_ap_start  <= 1'b0;
            r_ap_done   <= 1'b0;
            r_ap_idle   <= 1'b1;
            r_ss_tready <= 1'b0;
            r_sm_tvalid <= 1'b0;
            r_sm_tlast  <= 1'b0;
            r_sm_tdata  <= '0;
            r_out_cnt   <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            for (int i = 0; i < Tape_Num; i++) r_hist[i] <= '0;
        end else begin
            if (w_rd_fire && (araddr == c_ADDR_CTRL)) r_ap_done <= 1'b0;

            if (w_start) begin
                r_ap_start <= 1'b1;
                r_ap_idle  <= 1'b0;
                r_ap_done  <= 1'b0;
                r_out_cnt  <= pDATA_WIDTH'(1);
                for (int i = 0; i < Tape_Num; i++) r_hist[i] <= '0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (r_ap_start) begin
                        r_state     <= c_S_WAIT_IN;
                        r_ss_tready <= 1'b1;
                    end
                end
                c_S_WAIT_IN: begin
                    if (w_in_fire) begin
                        r_hist[0] <= ss_tdata;
                        for (int i = 1; i < Tape_Num; i++) r_hist[i] <= r_hist[i-1];
                        r_ap_start  <= 1'b0;
                        r_ss_tready <= 1'b0;
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_state     <= c_S_CALC;
                    end
                end
                c_S_CALC: begin
                    if (r_idx == c_IDX_W'(Tape_Num - 1)) begin
                        r_sm_tdata  <= r_acc + w_prod;
                        r_sm_tlast  <= w_last_out;
                        r_sm_tvalid <= 1'b1;
                        r_state     <= c_S_OUT;
                    end else begin
                        r_acc <= r_acc + w_prod;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    if (w_out_fire) begin
                        r_sm_tvalid <= 1'b0;
                        r_sm_tlast  <= 1'b0;
                        if (r_sm_tlast) begin
                            r_ap_done <= 1'b1;
                            r_ap_idle <= 1'b1;
                            r_state   <= c_S_IDLE;
                        end else begin
                            r_out_cnt   <= r_out_cnt + 1'b1;
                            r_ss_tready <= 1'b1;
                            r_state     <= c_S_WAIT_IN;
                        end
                    end
                end
            endcase
        end
    end

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign arready   = r_arready;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign ss_tready = r_ss_tready;
    assign sm_tvalid = r_sm_tvalid;
    assign sm_tdata  = r_sm_tdata;
    assign sm_tlast  = r_sm_tlast;

endmodule
`default_nettype wire

// File: tb/tb_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir
// Description : Scoreboard testbench for fir (register map, frames, stalls)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        awvalid, wvalid, arvalid, rready;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;

    int          n_cmp = 0;
    int          n_err = 0;
    int          h_model [11];
    int          xs [64];
    logic [32:0] exp_q [$];
    int          last_y;

    always #5 axis_clk = ~axis_clk;

    fir dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .sm_tvalid (sm_tvalid),
        .sm_tready (sm_tready),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    // Direct-form reference: y[n] = sum h[i]*x[n-i], 32-bit wrap.
    function automatic int model_y(input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < 11; i++) begin
            if (n - i >= 0) acc += h_model[i] * xs[n - i];
        end
        return acc;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int t;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; t = 0;
        @(negedge axis_clk);
        while (!(awready && wready) && t < 50) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL axi_write_timeout addr=%h got=no_ready want=ready", a);
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int t;
        araddr = a; arvalid = 1'b1; t = 0; d = 'x;
        @(negedge axis_clk);
        while (!arready && t < 50) begin
            @(negedge axis_clk);
            t++;
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(negedge axis_clk);
        while (!rvalid && t < 100) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL axi_read_timeout addr=%h got=no_rvalid want=rvalid", a);
        end else begin
            d = rdata;
        end
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [11:0] a, input logic [31:0] want);
        logic [31:0] got;
        axi_read(a, got);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s addr=%h got=%h want=%h", name, a, got, want);
        end
    endtask

    task automatic start_frame();
        exp_q.delete();
        axi_write(12'h000, 32'h1);
    endtask

    task automatic stream_frame(input int n_send, input int len, input int stall_idx,
                                input int stall_cyc, input bit busy_wr);
        fork
            begin
                for (int n = 0; n < n_send; n++) begin
                    int t;
                    t = 0;
                    ss_tdata = xs[n]; ss_tvalid = 1'b1;
                    @(negedge axis_clk);
                    while (!ss_tready && t < 400) begin
                        @(negedge axis_clk);
                        t++;
                    end
                    if (t >= 400) begin
                        n_cmp++; n_err++;
                        $display("FAIL ss_tready_timeout sample=%0d got=0 want=1", n);
                        ss_tvalid = 1'b0;
                        break;
                    end
                    @(posedge axis_clk); #1;
                    ss_tvalid = 1'b0;
                    exp_q.push_back({(n == len - 1), model_y(n)});
                end
            end
            begin
                for (int k = 0; k < n_send; k++) begin
                    int t;
                    logic [32:0] e;
                    t = 0;
                    sm_tready = (k == stall_idx) ? 1'b0 : 1'b1;
                    @(negedge axis_clk);
                    while (!sm_tvalid && t < 400) begin
                        @(negedge axis_clk);
                        t++;
                    end
                    if (t >= 400) begin
                        n_cmp++; n_err++;
                        $display("FAIL sm_tvalid_timeout output=%0d got=0 want=1", k);
                        break;
                    end
                    if (k == stall_idx) begin
                        for (int s = 0; s < stall_cyc; s++) begin
                            n_cmp++;
                            if (exp_q.size() == 0 || sm_tvalid !== 1'b1 ||
                                sm_tdata !== exp_q[0][31:0] || ss_tready !== 1'b0) begin
                                n_err++;
                                $display("FAIL stall cyc=%0d got valid=%b data=%0d ss_tready=%b want valid=1 data=%0d ss_tready=0",
                                         s, sm_tvalid, $signed(sm_tdata), ss_tready,
                                         (exp_q.size() == 0) ? 0 : $signed(exp_q[0][31:0]));
                            end
                            @(negedge axis_clk);
                        end
                        sm_tready = 1'b1;
                    end
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL output_unexpected idx=%0d got=%0d want=none", k, $signed(sm_tdata));
                    end else begin
                        e = exp_q.pop_front();
                        if ({sm_tlast, sm_tdata} !== e) begin
                            n_err++;
                            $display("FAIL output idx=%0d got data=%0d last=%b want data=%0d last=%b",
                                     k, $signed(sm_tdata), sm_tlast, $signed(e[31:0]), e[32]);
                        end
                    end
                    last_y = sm_tdata;
                    @(posedge axis_clk); #1;
                end
                sm_tready = 1'b1;
            end
            begin
                if (busy_wr) begin
                    repeat (60) @(posedge axis_clk);
                    #1;
                    axi_write(12'h020, 32'd5);
                end
            end
        join
    endtask

    task automatic test_reset();
        axis_rst_n = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast} !== 7'b0 ||
            rdata !== 32'h0 || sm_tdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got ctl=%b rdata=%h sm_tdata=%h want all zero",
                     {awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, rdata, sm_tdata);
        end
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        check_reg("reset_ap_ctrl", 12'h000, 32'h4);
    endtask

    task automatic test_regs();
        int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        axi_write(12'h010, 32'd64);
        for (int i = 0; i < 11; i++) begin
            h_model[i] = taps[i];
            axi_write(12'(32'h20 + 4 * i), 32'(taps[i]));
        end
        check_reg("readback_len", 12'h010, 32'd64);
        for (int i = 0; i < 11; i++) check_reg("readback_tap", 12'(32'h20 + 4 * i), 32'(taps[i]));
    endtask

    task automatic test_frame();
        start_frame();
        stream_frame(64, 64, -1, 0, 1'b0);
        n_cmp++;
        if (last_y !== 10614) begin
            n_err++;
            $display("FAIL final_output got=%0d want=10614", last_y);
        end
        check_reg("done_idle", 12'h000, 32'h6);
        check_reg("done_cleared", 12'h000, 32'h4);
    endtask

    task automatic test_backpressure();
        start_frame();
        stream_frame(64, 64, 5, 20, 1'b0);
        check_reg("bp_done", 12'h000, 32'h6);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            start_frame();
            stream_frame(64, 64, -1, 0, 1'b0);
            check_reg("b2b_done", 12'h000, 32'h6);
        end
    endtask

    task automatic test_busy_write();
        start_frame();
        stream_frame(64, 64, -1, 0, 1'b1);
        check_reg("busy_tap0", 12'h020, 32'h0);
        check_reg("busy_done", 12'h000, 32'h6);
    endtask

    task automatic test_len_zero();
        h_model[0] = 3;
        axi_write(12'h020, 32'd3);
        axi_write(12'h010, 32'd0);
        xs[0] = -7;
        start_frame();
        check_reg("started", 12'h000, 32'h1);
        stream_frame(1, 1, -1, 0, 1'b0);
        check_reg("len0_done", 12'h000, 32'h6);
        h_model[0] = 0;
        axi_write(12'h020, 32'd0);
        axi_write(12'h010, 32'd64);
        xs[0] = 0;
    endtask

    task automatic test_midframe_reset();
        int t;
        bit quiet;
        start_frame();
        stream_frame(15, 64, -1, 0, 1'b0);
        ss_tdata = xs[15]; ss_tvalid = 1'b1; t = 0;
        @(negedge axis_clk);
        while (!ss_tready && t < 400) begin
            @(negedge axis_clk);
            t++;
        end
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast} !== 7'b0 ||
            rdata !== 32'h0 || sm_tdata !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got ctl=%b rdata=%h sm_tdata=%h want all zero",
                     {awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, rdata, sm_tdata);
        end
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge axis_clk);
            if (sm_tvalid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_err++;
            $display("FAIL midreset_no_partial got sm_tvalid=1 want=0");
        end
        @(posedge axis_clk); #1;
        check_reg("midreset_ctrl", 12'h000, 32'h4);
        check_reg("midreset_tap1", 12'h024, 32'h0);
        check_reg("midreset_len", 12'h010, 32'h0);
    endtask

    initial begin
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 1'b1;
        last_y = 0;
        for (int i = 0; i < 11; i++) h_model[i] = 0;
        for (int n = 0; n < 64; n++) xs[n] = n;

        test_reset();
        test_regs();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_busy_write();
        test_len_zero();
        test_midframe_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
